mult_fu: RTL
============

# mult_fu

Pipelined integer multiply functional unit that consumes one `issued_mult` lane from the reservation station. Computes MUL/MULH/MULHSU/MULHU over `STAGES` cycles, holds the finished result until the CDB arbiter grants it, and drives `fu_mult_busy` back to the RS. Tracks branch masks in every stage so speculative multiplies are squashed or cleared in flight.

## Interface

- `STAGES`, 4: pipeline depth. Legal values are 1, 2, 4, 8. Each stage retires 64/`STAGES` multiplier bits.
- `clock` in 1: single clock. All state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `rs_in` in RS_PACKET: issued multiply. `valid` qualifies it; `func` is MULT_FUNC; dest tag and `b_mask` are carried through.
- `rs1_val`, `rs2_val` in 32 each: operand values, valid with `rs_in`.
- `br_id` in BR_MASK: one-hot branch being resolved.
- `br_task` in BR_TASK: NOTHING / SQUASH / CLEAR.
- `cdb_gnt` in 1: CDB arbiter accepts the held result this cycle.
- `busy` out 1: FU cannot accept an issue this cycle. Connects to `fu_mult_busy[i]`.
- `cdb_req` out 1: a result is held and requests the CDB.
- `fu_out` out MULT_RESULT_PACKET: `valid`, dest tag, 32-bit `result`, `b_mask`.
- `early_valid` out 1, `early_tag` out PHYS_REG_IDX: present only with `MULT_FU_EARLY_TAG_EN`.

## Operation

- Stage 0 latches the operands, sign-extended to 64 bits per func:
  - MUL, MULH: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
- Each stage adds `mcand * mplier[chunk]`, shifted, to its partial sum. Arithmetic is mod 2^64.
- Result selection: MUL returns `product[31:0]`. All other funcs return `product[63:32]`.
- The output register holds one completed op. `cdb_req` = `fu_out.valid`.
- Advance rule: `advance = ~fu_out.valid | cdb_gnt`. All stages and the output register move together only when `advance` is high. Otherwise every stage holds.
- `busy = ~advance`. This is combinational, so the RS sees it in the same cycle.
- Issue while `busy` is high is a protocol violation: the input is dropped, and a simulation-only assertion fires.
- Branch handling applies to every stage, the output register, and the incoming `rs_in` in the same cycle:
  - SQUASH: any entry with `(b_mask & br_id) != 0` has its valid cleared.
  - CLEAR: `b_mask ^= br_id` wherever `(b_mask & br_id) != 0`.
- A squash of the held output drops `cdb_req` on the next cycle. It frees the stall even without `cdb_gnt`.
- If `cdb_gnt` arrives while the held output is squashed in the same cycle, the squash wins. The arbiter must qualify the grant with the same-cycle `br_task`.
- Bubbles propagate. Stages never compact when stalled.

## Timing

- Issue at cycle t with no stall → `fu_out.valid` high from cycle t+`STAGES`.
- The result is consumed at the first edge where `cdb_gnt` is high. Back-to-back issues give one result per cycle when `cdb_gnt` stays high.
- Reset values: every stage valid = 0; `fu_out` = 0; `cdb_req` = 0; `busy` = 0; `early_valid` = 0.
- Reset mid-operation discards all in-flight ops. There is no output on the next cycle.
- Stall and squash together: squash clears valids in place, the pipeline does not advance, and `busy` recomputes next cycle.

## Configuration

- `MULT_FU_EARLY_TAG_EN` defined:
  - `early_valid` = last stage valid & `advance` & not squashed this cycle.
  - `early_tag` = that op's dest tag.
  - This lets the RS wake dependents one cycle before the CDB broadcast.
- Not defined: the ports are absent, and wakeup relies on the CDB only.

## Structure

- Shared package `sys_defs`: MULT_FUNC enum, MULT_RESULT_PACKET, reuse of RS_PACKET / BR_MASK / BR_TASK, PHYS_REG_IDX.
- One sub-module, `mult_stage`: one partial-product step plus branch-mask update. It is instantiated `STAGES` times through generate.

## Test plan

- MUL 7 × -3, no stall → `fu_out.result` = 0xFFFFFFEB at t+4, `cdb_req` = 1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same → 0xFFFFFFFF.
- Four back-to-back issues with `cdb_gnt` low from cycle 4:
  - `busy` = 1 from cycle 4.
  - All four results emerge in order, one per grant cycle after `cdb_gnt` rises.
- Ops with `b_mask` 0b01 and 0b10 in flight, SQUASH `br_id` = 0b10 → only the 0b10 op disappears. CLEAR 0b01 → the surviving op emerges with `b_mask` 0.
- Held output stalled, SQUASH on its mask with `cdb_gnt` = 1 → no broadcast, `cdb_req` = 0 and `busy` = 0 next cycle.
- With `MULT_FU_EARLY_TAG_EN`: tag 12 issued at t → `early_valid` with `early_tag` = 12 at t+3 and `fu_out` at t+4. Reset at t+2 → neither appears.

Source files
------------

// File: rtl/sys_defs.sv
// Shared types for the multiply functional unit: branch masks, RS issue
// packet, multiply func encoding, result packet and the in-flight stage packet.
package sys_defs;

    localparam int XLEN   = 32;
    localparam int BR_W   = 4;
    localparam int PHYS_W = 6;

    typedef logic [PHYS_W-1:0] PHYS_REG_IDX;
    typedef logic [BR_W-1:0]   BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        SQUASH  = 2'd1,
        CLEAR   = 2'd2
    } BR_TASK;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        PHYS_REG_IDX dest_tag;
        BR_MASK      b_mask;
    } RS_PACKET;

    typedef struct packed {
        logic            valid;
        PHYS_REG_IDX     dest_tag;
        logic [XLEN-1:0] result;
        BR_MASK          b_mask;
    } MULT_RESULT_PACKET;

    // One op in flight: operands already extended to 64 bits, running sum.
    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        PHYS_REG_IDX dest_tag;
        BR_MASK      b_mask;
        logic [63:0] mcand;
        logic [63:0] mplier;
        logic [63:0] sum;
    } MULT_STAGE_PACKET;

    function automatic logic br_hit(input BR_MASK mask, input BR_MASK id);
        return |(mask & id);
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiply pipeline register: folds one multiplier chunk into the running
// sum while advancing, and applies the branch squash/clear to whichever entry
// it ends up holding (incoming when advancing, its own when stalled).
module mult_stage
    import sys_defs::*;
#(
    parameter int CHUNK = 16,
    parameter int SHIFT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  BR_MASK           br_id,
    input  BR_TASK           br_task,
    input  MULT_STAGE_PACKET in_pkt,
    output MULT_STAGE_PACKET q
);

    MULT_STAGE_PACKET src;
    MULT_STAGE_PACKET nxt;
    logic [63:0]      mp_chunk;
    logic [63:0]      pp;

    // Select the entry kept this cycle, add its partial product, update masks.
    always_comb begin
        src                     = advance ? in_pkt : q;
        mp_chunk                = '0;
        mp_chunk[CHUNK-1:0]     = src.mplier[SHIFT +: CHUNK];
        pp                      = src.mcand * mp_chunk;
        nxt                     = src;
        if (advance)
            nxt.sum = src.sum + (pp << SHIFT);
        if (br_hit(src.b_mask, br_id)) begin
            if (br_task == SQUASH)
                nxt.valid = 1'b0;
            else if (br_task == CLEAR)
                nxt.b_mask = src.b_mask ^ br_id;
        end
    end

    // Pipeline register; reset empties the whole entry.
    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) over STAGES cycles.
// The last stage register doubles as the output register held for the CDB.
// Optional: define MULT_FU_EARLY_TAG_EN for a one-cycle-early wakeup tag.
module mult_fu
    import sys_defs::*;
#(
    parameter int STAGES = 4  // 1, 2, 4 or 8
) (
    input  logic              clock,
    input  logic              reset,
    input  RS_PACKET          rs_in,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  BR_MASK            br_id,
    input  BR_TASK            br_task,
    input  logic              cdb_gnt,
    output logic              busy,
    output logic              cdb_req,
    output MULT_RESULT_PACKET fu_out
`ifdef MULT_FU_EARLY_TAG_EN
    ,
    output logic              early_valid,
    output PHYS_REG_IDX       early_tag
`endif
);

    localparam int CHUNK = 64 / STAGES;

    MULT_STAGE_PACKET issue_pkt;
    MULT_STAGE_PACKET stg_in [STAGES];
    MULT_STAGE_PACKET stg_q  [STAGES];
    MULT_STAGE_PACKET last;
    logic             advance;

    assign last    = stg_q[STAGES-1];
    // Whole pipe moves in lockstep; a held result blocks everything behind it.
    assign advance = ~last.valid | cdb_gnt;
    assign busy    = ~advance;
    assign cdb_req = last.valid;

    // Build the stage-0 entry: extend operands according to signedness of func.
    always_comb begin
        issue_pkt          = '0;
        issue_pkt.valid    = rs_in.valid;
        issue_pkt.func     = rs_in.func;
        issue_pkt.dest_tag = rs_in.dest_tag;
        issue_pkt.b_mask   = rs_in.b_mask;
        issue_pkt.mcand    = (rs_in.func == MULHU) ? {32'b0, rs1_val}
                                                   : {{32{rs1_val[31]}}, rs1_val};
        issue_pkt.mplier   = (rs_in.func == MUL || rs_in.func == MULH)
                             ? {{32{rs2_val[31]}}, rs2_val} : {32'b0, rs2_val};
    end

    // Stages are chained; stage 0 takes the issue (ignored while stalled).
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_in[k] = issue_pkt;
        end else begin : g_body
            assign stg_in[k] = stg_q[k-1];
        end
        mult_stage #(
            .CHUNK (CHUNK),
            .SHIFT (k * CHUNK)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .advance (advance),
            .br_id   (br_id),
            .br_task (br_task),
            .in_pkt  (stg_in[k]),
            .q       (stg_q[k])
        );
    end

    // Result word selection from the full 64-bit product.
    always_comb begin
        fu_out          = '0;
        fu_out.valid    = last.valid;
        fu_out.dest_tag = last.dest_tag;
        fu_out.b_mask   = last.b_mask;
        fu_out.result   = (last.func == MUL) ? last.sum[31:0] : last.sum[63:32];
    end

`ifdef MULT_FU_EARLY_TAG_EN
    // Op entering the output register at the next edge, unless squashed now.
    assign early_valid = stg_in[STAGES-1].valid & advance & ~reset
                       & ~(br_task == SQUASH && br_hit(stg_in[STAGES-1].b_mask, br_id));
    assign early_tag   = stg_in[STAGES-1].dest_tag;
`endif

`ifndef SYNTHESIS
    // An issue into a stalled unit is silently lost; flag the RS bug.
    always_ff @(posedge clock) begin
        if (!reset)
            assert (!(rs_in.valid && busy))
                else $error("mult_fu: issue while busy, op dropped");
    end
`endif

endmodule
